// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I-cache/D-cache memory arbiter.
// Arbitration policy is chosen by the MEM_ARB_ROUND_ROBIN_EN macro (see mem_arb_pick).
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IC_BUSY = 2'd1,
    DC_BUSY = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the I-cache and D-cache requesters.
// MEM_ARB_ROUND_ROBIN_EN defined: tie goes to the requester not granted last; else D-cache wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    ic_req,
  input  logic    dc_req,
  input  logic    grant_en,
  output logic    grant_valid,
  output req_id_e grant_id
);

  assign grant_valid = ic_req | dc_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_IC;
    end else if (grant_en && grant_valid) begin
      last_q <= grant_id;
    end
  end

  always_comb begin
    grant_id = REQ_IC;
    if (ic_req && dc_req) begin
      grant_id = (last_q == REQ_DC) ? REQ_IC : REQ_DC;
    end else if (dc_req) begin
      grant_id = REQ_DC;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, grant_en};

  always_comb begin
    grant_id = dc_req ? REQ_DC : REQ_IC;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of a single line-wide memory port.
// Optional round-robin tie-break via MEM_ARB_ROUND_ROBIN_EN; default is fixed D-cache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic    grant_valid;
  req_id_e grant_id;

  mem_arb_pick u_pick (
    .clk         (clk),
    .rst         (rst),
    .ic_req      (ic_read),
    .dc_req      (dc_read | dc_write),
    .grant_en    (state_q == IDLE),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          if (grant_id == REQ_DC) begin
            state_d    = DC_BUSY;
            mem_addr_d = dc_addr;
            // A write-back takes precedence over a simultaneous fill from the same cache.
            if (dc_write) begin
              mem_write_d = 1'b1;
              mem_wdata_d = dc_wdata;
            end else begin
              mem_read_d  = 1'b1;
              mem_wdata_d = '0;
            end
          end else begin
            state_d     = IC_BUSY;
            mem_addr_d  = ic_addr;
            mem_wdata_d = '0;
            mem_read_d  = 1'b1;
          end
        end
      end
      IC_BUSY, DC_BUSY: begin
        if (mem_ready) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ic_ready = !rst && (state_q == IC_BUSY) && mem_ready;
  assign dc_ready = !rst && (state_q == DC_BUSY) && mem_ready;
  assign ic_rdata = ic_ready ? mem_rdata : '0;
  assign dc_rdata = dc_ready ? mem_rdata : '0;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory/ready events, a negedge monitor checks them.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic          dc;
    logic [DW-1:0] data;
  } rdy_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_read, dc_read, dc_write, mem_ready;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [DW-1:0] dc_wdata, mem_rdata;
  logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic          ic_ready, dc_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;

  mem_exp_t mem_q[$];
  rdy_exp_t rdy_q[$];
  mem_exp_t cur;
  logic     strobe_seen;
  int       n_cmp = 0;
  int       n_err = 0;
  logic     ic_first;

  localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] PAT_D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] PAT_D2 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
  localparam logic [DW-1:0] PAT_D3 = 128'h0BAD_F00D_0000_0000_0000_0000_0000_0003;
  localparam logic [DW-1:0] PAT_D4 = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
  localparam logic [DW-1:0] PAT_D5 = 128'h5555_0000_0000_0000_0000_0000_0000_0005;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ic_read   (ic_read),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_ready  (ic_ready),
    .dc_read   (dc_read),
    .dc_write  (dc_write),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_rdata  (dc_rdata),
    .dc_ready  (dc_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT starts a memory transaction or pulses a ready.
  always @(negedge clk) begin
    if (rst) begin
      check("ready_in_reset", {126'd0, ic_ready, dc_ready}, '0);
      strobe_seen = 1'b0;
    end else begin
      check("strobe_excl", {127'd0, mem_read & mem_write}, '0);
      if (mem_read || mem_write) begin
        if (!strobe_seen) begin
          if (mem_q.size() == 0) begin
            check("unexpected_mem_txn", {mem_write, mem_addr}, '0);
          end else begin
            cur = mem_q.pop_front();
            strobe_seen = 1'b1;
          end
        end
        if (strobe_seen) begin
          check("mem_write", {127'd0, mem_write}, {127'd0, cur.wr});
          check("mem_read", {127'd0, mem_read}, {127'd0, !cur.wr});
          check("mem_addr", {{(DW-AW){1'b0}}, mem_addr}, {{(DW-AW){1'b0}}, cur.addr});
          if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
        end
      end else begin
        strobe_seen = 1'b0;
      end
      check("both_ready", {127'd0, ic_ready & dc_ready}, '0);
      if (ic_ready || dc_ready) begin
        if (rdy_q.size() == 0) begin
          check("unexpected_ready", {126'd0, ic_ready, dc_ready}, '0);
        end else begin
          rdy_exp_t r;
          r = rdy_q.pop_front();
          check("ready_who", {126'd0, ic_ready, dc_ready}, {126'd0, !r.dc, r.dc});
          check("rdata", r.dc ? dc_rdata : ic_rdata, r.data);
        end
      end
      if (!ic_ready) check("ic_rdata_zero", ic_rdata, '0);
      if (!dc_ready) check("dc_rdata_zero", dc_rdata, '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe();
    int k = 0;
    while (!(mem_read || mem_write) && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) check("strobe_timeout", 128'd0, 128'd1);
  endtask

  // Answer the current memory transaction after lat cycles, then retire the requester.
  task automatic serve(input logic who_dc, input int lat, input logic [DW-1:0] data, input logic hold);
    wait_strobe();
    repeat (lat - 1) step();
    mem_ready = 1'b1;
    mem_rdata = data;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (hold) step();
    if (who_dc) begin
      dc_read  = 1'b0;
      dc_write = 1'b0;
    end else begin
      ic_read = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ic_read = 0; dc_read = 0; dc_write = 0; mem_ready = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    strobe_seen = 1'b0;
    step(); step();
    check("rst_mem_read", {127'd0, mem_read}, '0);
    check("rst_mem_write", {127'd0, mem_write}, '0);
    check("rst_mem_addr", {{(DW-AW){1'b0}}, mem_addr}, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    rst = 1'b0;
    step();

    // Single I-cache fill, 1-cycle grant, 5-cycle memory latency, request held through DONE.
    ic_addr = 28'h0000010; ic_read = 1'b1;
    mem_q.push_back('{1'b0, 28'h0000010, '0});
    rdy_q.push_back('{1'b0, PAT_A5});
    step();
    check("grant_lat_rd", {127'd0, mem_read}, 128'd1);
    check("grant_lat_addr", {{(DW-AW){1'b0}}, mem_addr}, 128'h10);
    serve(1'b0, 5, PAT_A5, 1'b0);
    check("strobe_clear", {126'd0, mem_read, mem_write}, '0);
    ic_read = 1'b1;
    step();
    check("done_no_grant", {126'd0, mem_read, mem_write}, '0);
    ic_read = 1'b0;
    step();
    check("no_regrant", {126'd0, mem_read, mem_write}, '0);

    // Tie after an I-cache grant: D-cache first under either policy.
    ic_addr = 28'h0000100; dc_addr = 28'h0000200;
    mem_q.push_back('{1'b0, 28'h0000200, '0});
    mem_q.push_back('{1'b0, 28'h0000100, '0});
    rdy_q.push_back('{1'b1, PAT_D1});
    rdy_q.push_back('{1'b0, PAT_D2});
    ic_read = 1'b1; dc_read = 1'b1;
    serve(1'b1, 2, PAT_D1, 1'b0);
    serve(1'b0, 3, PAT_D2, 1'b0);
    step(); step();

    // Write-back with a simultaneous fill request: write only.
    dc_addr = 28'h000003C; dc_wdata = 128'h1234;
    mem_q.push_back('{1'b1, 28'h000003C, 128'h1234});
    rdy_q.push_back('{1'b1, PAT_D3});
    dc_write = 1'b1; dc_read = 1'b1;
    serve(1'b1, 2, PAT_D3, 1'b0);
    step(); step();

    // Tie after a D-cache grant: policy decides the order.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ic_first = 1'b1;
`else
    ic_first = 1'b0;
`endif
    ic_addr = 28'h0000400; dc_addr = 28'h0000500;
    if (ic_first) begin
      mem_q.push_back('{1'b0, 28'h0000400, '0});
      mem_q.push_back('{1'b0, 28'h0000500, '0});
      rdy_q.push_back('{1'b0, PAT_D4});
      rdy_q.push_back('{1'b1, PAT_D5});
    end else begin
      mem_q.push_back('{1'b0, 28'h0000500, '0});
      mem_q.push_back('{1'b0, 28'h0000400, '0});
      rdy_q.push_back('{1'b1, PAT_D4});
      rdy_q.push_back('{1'b0, PAT_D5});
    end
    ic_read = 1'b1; dc_read = 1'b1;
    serve(!ic_first, 2, PAT_D4, 1'b0);
    serve(ic_first, 2, PAT_D5, 1'b0);
    step(); step();

    // Reset during DC_BUSY, then a stale mem_ready must be ignored.
    dc_addr = 28'h0000077;
    mem_q.push_back('{1'b0, 28'h0000077, '0});
    dc_read = 1'b1;
    wait_strobe();
    step();
    rst = 1'b1; dc_read = 1'b0; mem_ready = 1'b1; mem_rdata = PAT_D1;
    #1;
    check("rst_ready_low", {126'd0, ic_ready, dc_ready}, '0);
    step();
    check("rst_mid_strobes", {126'd0, mem_read, mem_write}, '0);
    check("rst_mid_addr", {{(DW-AW){1'b0}}, mem_addr}, '0);
    check("rst_mid_wdata", mem_wdata, '0);
    rst = 1'b0;
    #1;
    check("stale_ready", {126'd0, ic_ready, dc_ready}, '0);
    step();
    mem_ready = 1'b0; mem_rdata = '0;
    check("post_rst_idle", {126'd0, mem_read, mem_write}, '0);
    step(); step();

    check("mem_q_empty", 128'(mem_q.size()), '0);
    check("rdy_q_empty", 128'(rdy_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 28, block address width (word address of 128-bit lines).
REQ-002 Parameter: DATA_W, 128, line data width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: ic_read  input  1  I-cache line-fill request; held until ic_ready.
REQ-006 Port: ic_addr  input  ADDR_W  I-cache request address.
REQ-007 Port: ic_rdata  output  DATA_W  line returned to I-cache.
REQ-008 Port: ic_ready  output  1  I-cache transaction complete, one-cycle pulse.
REQ-009 Port: dc_read  input  1  D-cache line-fill request; held until dc_ready.
REQ-010 Port: dc_write  input  1  D-cache write-back request; held until dc_ready.
REQ-011 Port: dc_addr  input  ADDR_W  D-cache request address.
REQ-012 Port: dc_wdata  input  DATA_W  D-cache write-back line.
REQ-013 Port: dc_rdata  output  DATA_W  line returned to D-cache.
REQ-014 Port: dc_ready  output  1  D-cache transaction complete, one-cycle pulse.
REQ-015 Port: mem_read  output  1  memory read strobe, registered.
REQ-016 Port: mem_write  output  1  memory write strobe, registered.
REQ-017 Port: mem_addr  output  ADDR_W  memory address, registered, stable for the whole transaction.
REQ-018 Port: mem_wdata  output  DATA_W  memory write data, registered, stable for the whole transaction.
REQ-019 Port: mem_rdata  input  DATA_W  memory read data, valid with mem_ready.
REQ-020 Port: mem_ready  input  1  memory transaction complete, one-cycle pulse.

Function
REQ-021 FSM states SHALL be IDLE, IC_BUSY, DC_BUSY, DONE.
REQ-022 IDLE: a pending request selected per REQ-025/REQ-034 SHALL, at the next edge, latch mem_addr/mem_wdata from that requester, assert mem_read or mem_write, and enter the matching BUSY state; grant latency is exactly 1 cycle.
REQ-023 BUSY: the memory strobes and latched address/data SHALL hold, and requester inputs SHALL be ignored, until mem_ready.
REQ-024 In a BUSY cycle with mem_ready=1, the granted requester's ready SHALL be 1 and its rdata SHALL equal mem_rdata combinationally; the strobes SHALL clear at the next edge and the state SHALL become DONE.
REQ-025 Default priority: D-cache over I-cache when both request in IDLE.
REQ-026 dc_write and dc_read both high SHALL issue a write only.
REQ-027 DONE SHALL last exactly one cycle, grant nothing, and return to IDLE, so a request that drops after ready is never re-granted.
REQ-028 ic_ready/dc_ready SHALL never be asserted outside BUSY, never both at once, and never for more than one cycle per transaction.
REQ-029 ic_rdata/dc_rdata SHALL be 0 whenever the corresponding ready is 0.
REQ-030 mem_read and mem_write SHALL never both be 1.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and set mem_read, mem_write, mem_addr, mem_wdata and the round-robin pointer to 0, including mid-transaction; a mem_ready arriving after such a reset SHALL be ignored.
REQ-032 While rst=1, ic_ready and dc_ready SHALL be 0.

Configuration
REQ-033 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-034 Defined: a 1-bit last-grant pointer SHALL update on each grant; on a tie, the requester not granted last SHALL win.
REQ-035 Undefined: fixed D-cache priority per REQ-025, with no pointer register.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the FSM state enum, requester-ID encoding (REQ_IC, REQ_DC), and ADDR_W/DATA_W defaults.
REQ-037 Grant selection SHALL be a sub-module mem_arb_pick (combinational pick plus optional pointer); all else is in mem_arbiter.

Verification
REQ-038 ic_read=1, ic_addr=0x0000010, mem_ready 5 cycles later with mem_rdata=0xA5...A5 -> mem_read=1 with mem_addr=0x0000010 one cycle after request; ic_ready pulses once with ic_rdata=0xA5...A5; next grant no earlier than 2 cycles later.
REQ-039 ic_read and dc_read both rise in one cycle, macro undefined -> DC served first, then IC; two mem_read transactions, DC address first.
REQ-040 Same as REQ-039 with MEM_ARB_ROUND_ROBIN_EN, after a prior DC grant -> IC served first.
REQ-041 dc_write=1, dc_wdata=0x1234, dc_addr=0x3C -> mem_write=1, mem_wdata=0x1234, mem_addr=0x3C; mem_read stays 0; dc_ready pulses on mem_ready.
REQ-042 rst=1 for 1 cycle during DC_BUSY, then stale mem_ready -> strobes 0 next edge, state IDLE, no ready pulse.
